// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller: FSM, decoder and condition logic for a multicycle ARM-subset core.
// Revision: 1.0
// ============================================================================
module multicycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] C_ALU_ADD = 2'b00;
  localparam logic [1:0] C_ALU_SUB = 2'b01;
  localparam logic [1:0] C_ALU_AND = 2'b10;
  localparam logic [1:0] C_ALU_ORR = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condok_q, condok_d;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_rd_pc;
  logic [1:0] w_dp_alu;
  logic       w_dp_arith;
  logic       w_nowrite;
  logic       w_cond_met;
  logic       w_pcwrite, w_irwrite, w_regwrite, w_memwrite;
  logic       unused_instr;

  assign w_cond       = Instr[31:28];
  assign w_op         = Instr[27:26];
  assign w_funct      = Instr[25:20];
  assign w_rd         = Instr[15:12];
  assign w_rd_pc      = (w_rd == 4'd15);
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  assign ImmSrc = w_op;
  assign RegSrc = {(w_op == 2'b01) && !w_funct[0], (w_op == 2'b10)};

  // NoWrite only applies to data-processing (CMP); memory ops reuse these Funct bits.
  always_comb begin
    w_dp_alu   = C_ALU_ADD;
    w_dp_arith = 1'b1;
    w_nowrite  = 1'b0;
    case (w_funct[4:1])
      4'b0100: w_dp_alu = C_ALU_ADD;
      4'b0010: w_dp_alu = C_ALU_SUB;
      4'b0000: begin w_dp_alu = C_ALU_AND; w_dp_arith = 1'b0; end
      4'b1100: begin w_dp_alu = C_ALU_ORR; w_dp_arith = 1'b0; end
      4'b1010: begin w_dp_alu = C_ALU_SUB; w_nowrite = (w_op == 2'b00); end
      default: w_dp_alu = C_ALU_ADD;
    endcase
  end

  always_comb begin
    w_cond_met = 1'b0;
    case (w_cond)
      4'b0000: w_cond_met = flags_q[2];
      4'b0001: w_cond_met = !flags_q[2];
      4'b0010: w_cond_met = flags_q[1];
      4'b0011: w_cond_met = !flags_q[1];
      4'b0100: w_cond_met = flags_q[3];
      4'b0101: w_cond_met = !flags_q[3];
      4'b0110: w_cond_met = flags_q[0];
      4'b0111: w_cond_met = !flags_q[0];
      4'b1000: w_cond_met = flags_q[1] && !flags_q[2];
      4'b1001: w_cond_met = !flags_q[1] || flags_q[2];
      4'b1010: w_cond_met = (flags_q[3] == flags_q[0]);
      4'b1011: w_cond_met = (flags_q[3] != flags_q[0]);
      4'b1100: w_cond_met = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: w_cond_met = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'b1110: w_cond_met = 1'b1;
      default: w_cond_met = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (w_op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = w_funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = w_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = C_ALU_ADD;
    case (state_q)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = condok_q && !w_nowrite;
        w_pcwrite  = condok_q && w_rd_pc && !w_nowrite;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        w_memwrite = condok_q;
      end
      S_EXECR:  ALUControl = w_dp_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_dp_alu;
      end
      S_ALUWB: begin
        w_regwrite = condok_q && !w_nowrite;
        w_pcwrite  = condok_q && w_rd_pc && !w_nowrite;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcwrite = condok_q;
      end
      default: ;
    endcase
  end

  // Write enables are held off for as long as reset is low, not just at the edge.
  assign PCWrite  = w_pcwrite  && rst_n;
  assign IRWrite  = w_irwrite  && rst_n;
  assign RegWrite = w_regwrite && rst_n;
  assign MemWrite = w_memwrite && rst_n;

  always_comb begin
    flags_d  = flags_q;
    condok_d = condok_q;
    if (state_q == S_DECODE) condok_d = w_cond_met;
    if (((state_q == S_EXECR) || (state_q == S_EXECI)) && condok_q && w_funct[0]) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (w_dp_arith) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condok_q <= condok_d;
    end
  end

  assign Flags = flags_q;
  assign State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller: random and directed instructions against an instruction-level model.
// Revision: 1.0
// ============================================================================
module tb_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  Flags, State;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [3:0]  m_flags;
  logic [5:0]  sel_tab [10];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Flags(Flags), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy & !z;    9: return !cy | z;
      10: return n == v;    11: return n != v;
      12: return !z & (n == v);
      13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Data-processing op from Funct[4:1]: 0 ADD, 1 SUB, 2 AND, 3 ORR.
  function automatic logic [1:0] dp_op(input logic [3:0] f41);
    case (f41)
      4'b0010, 4'b1010: return 2'd1;
      4'b0000:          return 2'd2;
      4'b1100:          return 2'd3;
      default:          return 2'd0;
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] alu);
    logic [1:0] op;
    logic [5:0] fn;
    logic       ok, nw, wb;
    logic [1:0] aop;
    int         st [6];
    int         len;
    op  = ins[27:26];
    fn  = ins[25:20];
    ok  = cond_holds(m_flags, ins[31:28]);
    aop = dp_op(fn[4:1]);
    nw  = (op == 2'b00) && (fn[4:1] == 4'b1010);
    Instr    = ins;
    ALUFlags = alu;
    st[0] = 0; st[1] = 1; len = 2;
    case (op)
      2'b01: begin
        st[2] = 2;
        if (fn[0]) begin st[3] = 3; st[4] = 4; len = 5; end
        else begin st[3] = 5; len = 4; end
      end
      2'b00: begin st[2] = fn[5] ? 7 : 6; st[3] = 8; len = 4; end
      2'b10: begin st[2] = 9; len = 3; end
      default: len = 2;
    endcase
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("state", State, st[i]);
      wb = (st[i] == 4) || (st[i] == 8);
      chk("irwrite", IRWrite, st[i] == 0);
      chk("pcwrite", PCWrite, (st[i] == 0) || (st[i] == 9 && ok) ||
                              (wb && ok && ins[15:12] == 4'd15 && !nw));
      chk("regwrite", RegWrite, wb && ok && !nw);
      chk("memwrite", MemWrite, st[i] == 5 && ok);
      chk("selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, sel_tab[st[i]]);
      chk("alucontrol", ALUControl, (st[i] == 6 || st[i] == 7) ? aop : 2'd0);
      chk("immsrc", ImmSrc, op);
      chk("regsrc", RegSrc, {(op == 2'b01) && !fn[0], op == 2'b10});
      @(posedge clk);
      #1;
    end
    if (op == 2'b00 && ok && fn[0]) begin
      m_flags[3:2] = alu[3:2];
      if (aop <= 2'd1) m_flags[1:0] = alu[1:0];
    end
    chk("flags_after", Flags, m_flags);
    chk("state_after", State, 0);
  endtask

  task automatic abort_in_memadr();
    Instr    = 32'hE5821004;
    ALUFlags = 4'b0000;
    @(negedge clk); chk("abort_s0", State, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_s1", State, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_memadr", State, 2);
    chk("abort_flags_pre", Flags, m_flags);
    chk("abort_enables", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
    @(posedge clk); #1;
    chk("abort_memwrite", MemWrite, 1'b0);
    rst_n   = 1'b1;
    m_flags = 4'b0000;
    chk("abort_state", State, 0);
    chk("abort_flags", Flags, 4'b0000);
  endtask

  initial begin
    logic [31:0] r;
    sel_tab[0] = 6'b011010; sel_tab[1] = 6'b011010; sel_tab[2] = 6'b000100;
    sel_tab[3] = 6'b100000; sel_tab[4] = 6'b000001; sel_tab[5] = 6'b100000;
    sel_tab[6] = 6'b000000; sel_tab[7] = 6'b000100; sel_tab[8] = 6'b000000;
    sel_tab[9] = 6'b000110;
    m_flags  = 4'b0000;
    rst_n    = 1'b0;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", State, 0);
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_irwrite_forced", IRWrite, 1'b0);
    chk("reset_pcwrite_forced", PCWrite, 1'b0);
    rst_n = 1'b1;

    run_instr(32'hE0821003, 4'b1111);
    run_instr(32'hE5921004, 4'b0000);
    run_instr(32'hE5821004, 4'b0000);
    run_instr(32'hE1510002, 4'b0100);
    chk("cmp_flags", Flags, 4'b0100);
    run_instr(32'h0A000002, 4'b0000);
    run_instr(32'hE0921003, 4'b0000);
    run_instr(32'h0A000002, 4'b0000);
    run_instr(32'hE1510002, 4'b0100);
    run_instr(32'h10821003, 4'b1011);
    chk("addne_flags", Flags, 4'b0100);
    run_instr(32'hE081F003, 4'b0000);
    run_instr(32'hE0921003, 4'b1111);
    chk("adds_flags", Flags, 4'b1111);
    abort_in_memadr();

    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
      if ($urandom_range(0, 2) == 0) r[31:28] = 4'hE;
      run_instr(r, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
